// File: rtl/cache_refill_ctrl.sv
// Cache refill controller: on a CPU miss, fetches one or two words from memory
// (a misaligned access can straddle two words) and writes them into the cache.
package package_project_typedefs;
  typedef enum logic [1:0] {
    CACHE_NO_RD   = 2'd0,
    CACHE_RD_WORD = 2'd1,
    CACHE_RD_HALF = 2'd2,
    CACHE_RD_BYTE = 2'd3
  } CacheRdControl;

  typedef enum logic [1:0] {
    CACHE_NO_WR = 2'd0,
    CACHE_W_WR  = 2'd1,
    CACHE_H_WR  = 2'd2,
    CACHE_B_WR  = 2'd3
  } CacheWrControl;
endpackage

module cache_refill_ctrl
  import package_project_typedefs::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   addr_in,
  input  logic [3:0]    cache_miss,
  output logic          cache_stall,
  output CacheRdControl cache_rd_type,
  output CacheWrControl cache_wr_en,
  output logic [31:0]   cache_addr,
  output logic [31:0]   cache_wr_data,
  output logic          cpu_stall,
  output logic          mem_rd_req,
  output logic [31:0]   mem_addr,
  input  logic          mem_rd_valid,
  input  logic [31:0]   mem_rd_data,
  output logic [15:0]   refill_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FILL_A  = 3'd2,
    FETCH_B = 3'd3,
    FILL_B  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic        need_b_q, need_b_d;
  logic [31:0] data_q, data_d;
  logic [15:0] count_q, count_d;

  logic        need_a, need_b;
  logic [1:0]  off;
  logic [31:0] addr_b;

  // Byte i of the access lands in word A while off+i < 4, otherwise in word B.
  always_comb begin
    need_a = 1'b0;
    need_b = 1'b0;
    off    = addr_in[1:0];
    for (int unsigned i = 0; i < 4; i++) begin
      if (cache_miss[i]) begin
        if ((32'(off) + i) < 32'd4) need_a = 1'b1;
        else                        need_b = 1'b1;
      end
    end
  end

  assign addr_b = base_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    need_b_d      = need_b_q;
    data_d        = data_q;
    count_d       = count_q;
    cache_rd_type = CACHE_NO_RD;
    cache_wr_en   = CACHE_NO_WR;
    cache_addr    = '0;
    cache_wr_data = '0;
    mem_rd_req    = 1'b0;
    mem_addr      = '0;

    case (state_q)
      IDLE: begin
        if (need_a || need_b) begin
          base_d   = {addr_in[31:2], 2'b00};
          need_b_d = need_b;
          state_d  = need_a ? FETCH_A : FETCH_B;
        end
      end
      FETCH_A: begin
        mem_rd_req = 1'b1;
        mem_addr   = base_q;
        if (mem_rd_valid) begin
          data_d  = mem_rd_data;
          state_d = FILL_A;
        end
      end
      FILL_A: begin
        cache_wr_en   = CACHE_W_WR;
        cache_addr    = base_q;
        cache_wr_data = data_q;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        state_d = need_b_q ? FETCH_B : IDLE;
      end
      FETCH_B: begin
        mem_rd_req = 1'b1;
        mem_addr   = addr_b;
        if (mem_rd_valid) begin
          data_d  = mem_rd_data;
          state_d = FILL_B;
        end
      end
      FILL_B: begin
        cache_wr_en   = CACHE_W_WR;
        cache_addr    = addr_b;
        cache_wr_data = data_q;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      need_b_q <= 1'b0;
      data_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      need_b_q <= need_b_d;
      data_q   <= data_d;
      count_q  <= count_d;
    end
  end

  assign cache_stall  = (state_q != IDLE);
  assign cpu_stall    = cache_stall | ((state_q == IDLE) & (|cache_miss));
  assign refill_count = count_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: single/split/upper-only refills,
// idle behaviour, reset mid-fetch, counter saturation and address wrap.
module tb_cache_refill_ctrl;
  import package_project_typedefs::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   addr_in;
  logic [3:0]    cache_miss;
  logic          cache_stall;
  CacheRdControl cache_rd_type;
  CacheWrControl cache_wr_en;
  logic [31:0]   cache_addr;
  logic [31:0]   cache_wr_data;
  logic          cpu_stall;
  logic          mem_rd_req;
  logic [31:0]   mem_addr;
  logic          mem_rd_valid;
  logic [31:0]   mem_rd_data;
  logic [15:0]   refill_count;

  int n_cmp  = 0;
  int n_fail = 0;

  cache_refill_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .addr_in      (addr_in),
    .cache_miss   (cache_miss),
    .cache_stall  (cache_stall),
    .cache_rd_type(cache_rd_type),
    .cache_wr_en  (cache_wr_en),
    .cache_addr   (cache_addr),
    .cache_wr_data(cache_wr_data),
    .cpu_stall    (cpu_stall),
    .mem_rd_req   (mem_rd_req),
    .mem_addr     (mem_addr),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .refill_count (refill_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; addr_in = '0; cache_miss = 4'b0000;
    mem_rd_valid = 1'b0; mem_rd_data = '0;
    tick(); tick();
    n_cmp++; if (cache_stall !== 1'b0) begin n_fail++; $display("FAIL rst_cache_stall got %0b exp 0", cache_stall); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_stall got %0b exp 0", cpu_stall); end
    n_cmp++; if (mem_rd_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rd_req got %0b exp 0", mem_rd_req); end
    n_cmp++; if (cache_wr_en !== CACHE_NO_WR) begin n_fail++; $display("FAIL rst_wr_en got %0d exp %0d", cache_wr_en, CACHE_NO_WR); end
    n_cmp++; if (cache_rd_type !== CACHE_NO_RD) begin n_fail++; $display("FAIL rst_rd_type got %0d exp %0d", cache_rd_type, CACHE_NO_RD); end
    n_cmp++; if (refill_count !== 16'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", refill_count); end
    // Reset held with a miss presented: stays IDLE, cpu_stall follows the miss.
    cache_miss = 4'b1111; addr_in = 32'd900;
    tick();
    n_cmp++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_stall_miss got %0b exp 1", cpu_stall); end
    n_cmp++; if (cache_stall !== 1'b0) begin n_fail++; $display("FAIL rst_cache_stall_miss got %0b exp 0", cache_stall); end
    cache_miss = 4'b0000;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_aligned();
    addr_in = 32'd900; cache_miss = 4'b1111;
    tick();
    cache_miss = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (mem_rd_req !== 1'b1) begin n_fail++; $display("FAIL al_req[%0d] got %0b exp 1", c, mem_rd_req); end
      n_cmp++; if (mem_addr !== 32'd900) begin n_fail++; $display("FAIL al_mem_addr[%0d] got %0d exp 900", c, mem_addr); end
      n_cmp++; if (cache_stall !== 1'b1) begin n_fail++; $display("FAIL al_stall[%0d] got %0b exp 1", c, cache_stall); end
      n_cmp++; if (cache_wr_en !== CACHE_NO_WR) begin n_fail++; $display("FAIL al_fetch_wr[%0d] got %0d exp 0", c, cache_wr_en); end
      if (c == 2) begin mem_rd_valid = 1'b1; mem_rd_data = 32'h11223344; end
      tick();
    end
    mem_rd_valid = 1'b0; mem_rd_data = '0;
    n_cmp++; if (cache_wr_en !== CACHE_W_WR) begin n_fail++; $display("FAIL al_fill_wr got %0d exp %0d", cache_wr_en, CACHE_W_WR); end
    n_cmp++; if (cache_addr !== 32'd900) begin n_fail++; $display("FAIL al_fill_addr got %0d exp 900", cache_addr); end
    n_cmp++; if (cache_wr_data !== 32'h11223344) begin n_fail++; $display("FAIL al_fill_data got %h exp 11223344", cache_wr_data); end
    n_cmp++; if (mem_rd_req !== 1'b0) begin n_fail++; $display("FAIL al_fill_req got %0b exp 0", mem_rd_req); end
    n_cmp++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL al_fill_cpu_stall got %0b exp 1", cpu_stall); end
    tick();
    n_cmp++; if (cache_stall !== 1'b0) begin n_fail++; $display("FAIL al_end_stall got %0b exp 0", cache_stall); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL al_end_cpu_stall got %0b exp 0", cpu_stall); end
    n_cmp++; if (cache_wr_en !== CACHE_NO_WR) begin n_fail++; $display("FAIL al_end_wr got %0d exp 0", cache_wr_en); end
    n_cmp++; if (cache_addr !== 32'd0) begin n_fail++; $display("FAIL al_end_addr got %0d exp 0", cache_addr); end
    n_cmp++; if (refill_count !== 16'd1) begin n_fail++; $display("FAIL al_count got %0d exp 1", refill_count); end
  endtask

  task automatic test_split();
    addr_in = 32'd903; cache_miss = 4'b1111;
    tick();
    cache_miss = 4'b0000;
    n_cmp++; if (mem_addr !== 32'd900) begin n_fail++; $display("FAIL sp_addr_a got %0d exp 900", mem_addr); end
    n_cmp++; if (mem_rd_req !== 1'b1) begin n_fail++; $display("FAIL sp_req_a got %0b exp 1", mem_rd_req); end
    mem_rd_valid = 1'b1; mem_rd_data = 32'hAAAA0001;
    tick();
    mem_rd_valid = 1'b0;
    n_cmp++; if (cache_wr_en !== CACHE_W_WR) begin n_fail++; $display("FAIL sp_fill_a_wr got %0d exp 1", cache_wr_en); end
    n_cmp++; if (cache_addr !== 32'd900) begin n_fail++; $display("FAIL sp_fill_a_addr got %0d exp 900", cache_addr); end
    n_cmp++; if (cache_wr_data !== 32'hAAAA0001) begin n_fail++; $display("FAIL sp_fill_a_data got %h exp aaaa0001", cache_wr_data); end
    n_cmp++; if (cache_stall !== 1'b1) begin n_fail++; $display("FAIL sp_stall_fill_a got %0b exp 1", cache_stall); end
    tick();
    n_cmp++; if (cache_stall !== 1'b1) begin n_fail++; $display("FAIL sp_stall_fetch_b got %0b exp 1", cache_stall); end
    n_cmp++; if (mem_rd_req !== 1'b1) begin n_fail++; $display("FAIL sp_req_b got %0b exp 1", mem_rd_req); end
    n_cmp++; if (mem_addr !== 32'd904) begin n_fail++; $display("FAIL sp_addr_b got %0d exp 904", mem_addr); end
    n_cmp++; if (cache_wr_en !== CACHE_NO_WR) begin n_fail++; $display("FAIL sp_fetch_b_wr got %0d exp 0", cache_wr_en); end
    mem_rd_valid = 1'b1; mem_rd_data = 32'hBBBB0002;
    tick();
    mem_rd_valid = 1'b0;
    n_cmp++; if (cache_wr_en !== CACHE_W_WR) begin n_fail++; $display("FAIL sp_fill_b_wr got %0d exp 1", cache_wr_en); end
    n_cmp++; if (cache_addr !== 32'd904) begin n_fail++; $display("FAIL sp_fill_b_addr got %0d exp 904", cache_addr); end
    n_cmp++; if (cache_wr_data !== 32'hBBBB0002) begin n_fail++; $display("FAIL sp_fill_b_data got %h exp bbbb0002", cache_wr_data); end
    tick();
    n_cmp++; if (cache_stall !== 1'b0) begin n_fail++; $display("FAIL sp_end_stall got %0b exp 0", cache_stall); end
    n_cmp++; if (refill_count !== 16'd3) begin n_fail++; $display("FAIL sp_count got %0d exp 3", refill_count); end
  endtask

  task automatic test_upper_only();
    addr_in = 32'd903; cache_miss = 4'b1110;
    tick();
    cache_miss = 4'b0000;
    n_cmp++; if (mem_addr !== 32'd904) begin n_fail++; $display("FAIL up_addr got %0d exp 904", mem_addr); end
    n_cmp++; if (mem_rd_req !== 1'b1) begin n_fail++; $display("FAIL up_req got %0b exp 1", mem_rd_req); end
    mem_rd_valid = 1'b1; mem_rd_data = 32'hCAFEF00D;
    tick();
    mem_rd_valid = 1'b0;
    n_cmp++; if (cache_addr !== 32'd904) begin n_fail++; $display("FAIL up_fill_addr got %0d exp 904", cache_addr); end
    n_cmp++; if (cache_wr_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL up_fill_data got %h exp cafef00d", cache_wr_data); end
    tick();
    n_cmp++; if (cache_stall !== 1'b0) begin n_fail++; $display("FAIL up_end_stall got %0b exp 0", cache_stall); end
    n_cmp++; if (refill_count !== 16'd4) begin n_fail++; $display("FAIL up_count got %0d exp 4", refill_count); end
  endtask

  task automatic test_no_miss();
    addr_in = 32'd1234; cache_miss = 4'b0000;
    mem_rd_valid = 1'b1; mem_rd_data = 32'hDEADBEEF;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++; if ({cache_stall, cpu_stall, mem_rd_req} !== 3'b000) begin n_fail++; $display("FAIL nm_ctl[%0d] got %b exp 000", c, {cache_stall, cpu_stall, mem_rd_req}); end
    end
    mem_rd_valid = 1'b0;
    n_cmp++; if (refill_count !== 16'd4) begin n_fail++; $display("FAIL nm_count got %0d exp 4", refill_count); end
  endtask

  task automatic test_reset_mid_fetch();
    addr_in = 32'd900; cache_miss = 4'b1111;
    tick();
    cache_miss = 4'b0000;
    n_cmp++; if (mem_rd_req !== 1'b1) begin n_fail++; $display("FAIL rm_req got %0b exp 1", mem_rd_req); end
    reset = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 32'h55555555;
    tick();
    reset = 1'b0; mem_rd_valid = 1'b0;
    n_cmp++; if (cache_stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall got %0b exp 0", cache_stall); end
    n_cmp++; if (mem_rd_req !== 1'b0) begin n_fail++; $display("FAIL rm_req_after got %0b exp 0", mem_rd_req); end
    n_cmp++; if (cache_wr_en !== CACHE_NO_WR) begin n_fail++; $display("FAIL rm_wr got %0d exp 0", cache_wr_en); end
    n_cmp++; if (refill_count !== 16'd0) begin n_fail++; $display("FAIL rm_count got %0d exp 0", refill_count); end
    tick();
    n_cmp++; if (cache_wr_en !== CACHE_NO_WR) begin n_fail++; $display("FAIL rm_wr_late got %0d exp 0", cache_wr_en); end
    n_cmp++; if (refill_count !== 16'd0) begin n_fail++; $display("FAIL rm_count_late got %0d exp 0", refill_count); end
  endtask

  task automatic test_saturation();
    force dut.count_q = 16'hFFFE;
    tick();
    release dut.count_q;
    tick();
    n_cmp++; if (refill_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload got %h exp fffe", refill_count); end
    for (int k = 0; k < 2; k++) begin
      addr_in = 32'd16; cache_miss = 4'b0001;
      tick();
      cache_miss = 4'b0000; mem_rd_valid = 1'b1; mem_rd_data = 32'h0;
      tick();
      mem_rd_valid = 1'b0;
      tick();
      n_cmp++; if (refill_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_count[%0d] got %h exp ffff", k, refill_count); end
    end
  endtask

  task automatic test_wrap();
    addr_in = 32'hFFFFFFFF; cache_miss = 4'b0011;
    tick();
    cache_miss = 4'b0000;
    n_cmp++; if (mem_addr !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wr_addr_a got %h exp fffffffc", mem_addr); end
    mem_rd_valid = 1'b1; mem_rd_data = 32'h01010101;
    tick();
    mem_rd_valid = 1'b0;
    n_cmp++; if (cache_addr !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wr_fill_a got %h exp fffffffc", cache_addr); end
    tick();
    n_cmp++; if ({mem_rd_req, mem_addr} !== {1'b1, 32'h00000000}) begin n_fail++; $display("FAIL wr_fetch_b got req=%0b addr=%h exp req=1 addr=0", mem_rd_req, mem_addr); end
    mem_rd_valid = 1'b1; mem_rd_data = 32'h02020202;
    tick();
    mem_rd_valid = 1'b0;
    n_cmp++; if ({cache_wr_en, cache_addr, cache_wr_data} !== {CACHE_W_WR, 32'h0, 32'h02020202}) begin n_fail++; $display("FAIL wr_fill_b got wr=%0d addr=%h data=%h exp wr=1 addr=0 data=02020202", cache_wr_en, cache_addr, cache_wr_data); end
    tick();
    n_cmp++; if (cache_stall !== 1'b0) begin n_fail++; $display("FAIL wr_end_stall got %0b exp 0", cache_stall); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_split();
    test_upper_only();
    test_no_miss();
    test_reset_mid_fetch();
    test_saturation();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL use types CacheWrControl and CacheRdControl from package_project_typedefs.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 addr_in  input  32  CPU byte address currently presented to the cache.
REQ-005 cache_miss  input  4  per-byte miss flags from cache; bit i covers byte addr_in+i.
REQ-006 cache_stall  output  1  gives cache port control to this block.
REQ-007 cache_rd_type  output  CacheRdControl  cache read type while stalled.
REQ-008 cache_wr_en  output  CacheWrControl  cache write type while stalled.
REQ-009 cache_addr  output  32  word-aligned cache fill address.
REQ-010 cache_wr_data  output  32  fill data.
REQ-011 cpu_stall  output  1  freezes CPU pipeline.
REQ-012 mem_rd_req  output  1  memory word-read request, held until accepted.
REQ-013 mem_addr  output  32  word-aligned memory read address.
REQ-014 mem_rd_valid  input  1  memory returns data this cycle; completes request.
REQ-015 mem_rd_data  input  32  memory read data, valid with mem_rd_valid.
REQ-016 refill_count  output  16  count of completed word fills, saturating.

Function
REQ-017 States: IDLE, FETCH_A, FILL_A, FETCH_B, FILL_B.
REQ-018 Decode in IDLE: off=addr_in[1:0]; need_A = any missed bit i with off+i<4; need_B = any missed bit i with off+i>=4; base = {addr_in[31:2],2'b00}; B address = base+4, wrapping mod 2^32.
REQ-019 IDLE: need_A -> FETCH_A; else need_B -> FETCH_B; else stay; need_A/need_B/base latched on the transition edge.
REQ-020 FETCH_x: mem_rd_req=1, mem_addr = latched word address; on mem_rd_valid latch mem_rd_data, go FILL_x; otherwise hold; no timeout.
REQ-021 FILL_x: cache_wr_en=CACHE_W_WR, cache_addr = word address, cache_wr_data = latched data, for exactly one cycle; refill_count increments unless 16'hFFFF.
REQ-022 FILL_A: latched need_B -> FETCH_B, else IDLE; FILL_B -> IDLE.
REQ-023 cache_stall = (state != IDLE), registered-state-derived only; never combinationally dependent on cache_miss.
REQ-024 cpu_stall = cache_stall | (state==IDLE & |cache_miss).
REQ-025 cache_rd_type = CACHE_NO_RD always; cache_wr_en = CACHE_NO_WR outside FILL states; cache_addr/cache_wr_data = 0 outside FILL states.
REQ-026 mem_rd_req = 0 and mem_addr = 0 outside FETCH states; mem_rd_valid outside FETCH ignored.
REQ-027 Latency: miss sampled at edge t -> mem_rd_req at t+1; mem_rd_valid at edge u -> cache write in cycle u+1; stall drops cycle after last FILL.
REQ-028 cache_miss changes during non-IDLE states are ignored; re-evaluated only in IDLE.
REQ-029 Single-word miss with all bytes in word B only (e.g. off=3, bits 3:1 set) fills B only.

Reset
REQ-030 On reset at any clock edge, including mid-FETCH/FILL: state=IDLE, latched data/addresses=0, refill_count=0; outputs next cycle: cache_stall=0, cpu_stall=|cache_miss, mem_rd_req=0, cache_wr_en=CACHE_NO_WR, cache_rd_type=CACHE_NO_RD.
REQ-031 Reset has priority over mem_rd_valid in the same cycle; that data is discarded and refill_count unchanged.

Verification
REQ-032 Aligned miss: addr_in=900, cache_miss=4'b1111, mem_rd_valid 3 cycles after req with 32'h11223344 -> mem_addr=900, one cycle cache_wr_en=CACHE_W_WR at cache_addr=900 data 32'h11223344, refill_count=1, stall low afterward.
REQ-033 Misaligned split: addr_in=903, cache_miss=4'b1111 -> fetch/fill 900 then 904, two fills, refill_count=2, cache_stall high continuously across both.
REQ-034 Upper-only: addr_in=903, cache_miss=4'b1110 -> only address 904 fetched/filled.
REQ-035 No miss: cache_miss=0 for 10 cycles -> cache_stall=0, cpu_stall=0, mem_rd_req=0, count unchanged.
REQ-036 Reset mid-FETCH with mem_rd_valid same cycle -> IDLE next cycle, no cache write, refill_count=0.
REQ-037 Saturation: preload 65535 fills (or force) then one more miss -> refill_count stays 16'hFFFF; wrap: addr_in=32'hFFFFFFFF, cache_miss=4'b0011 -> fills 32'hFFFFFFFC then 32'h00000000.
